// File: rtl/studio2_mem_arbiter_if.sv
// Bus bundle between the Studio II memory arbiter and its requesters / memory port.
// STUDIO2_VRAM_SNOOP_EN adds the vram_wr_stb / vram_wr_data snoop signals.
interface studio2_mem_arbiter_if #(
  parameter int AW = 12
);
  logic          cpu_req;
  logic          cpu_wr;
  logic [15:0]   cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ack;

  logic          dma_req;
  logic [7:0]    dma_offs;
  logic [7:0]    dma_rdata;
  logic          dma_ack;

  logic          ld_active;
  logic          ld_wr;
  logic [7:0]    ld_index;
  logic [24:0]   ld_addr;
  logic [7:0]    ld_data;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic          busy;
  logic          ld_overrun;
`ifdef STUDIO2_VRAM_SNOOP_EN
  logic          vram_wr_stb;
  logic [7:0]    vram_wr_data;
`endif

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_offs,
    output dma_rdata, dma_ack,
    input  ld_active, ld_wr, ld_index, ld_addr, ld_data,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output busy, ld_overrun
`ifdef STUDIO2_VRAM_SNOOP_EN
    , output vram_wr_stb, vram_wr_data
`endif
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_offs,
    input  dma_rdata, dma_ack,
    output ld_active, ld_wr, ld_index, ld_addr, ld_data,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  busy, ld_overrun
`ifdef STUDIO2_VRAM_SNOOP_EN
    , input vram_wr_stb, vram_wr_data
`endif
  );
endinterface

// File: rtl/studio2_mem_arbiter.sv
// Shares the 4 KB Studio II memory between ioctl loader, pixie DMA and the CDP1802 CPU.
// Optional: define STUDIO2_VRAM_SNOOP_EN for a strobe on CPU writes landing in VRAM.
module studio2_mem_arbiter #(
  parameter int            AW          = 12,
  parameter logic [AW-1:0] VRAM_BASE   = 12'h900,
  parameter logic [AW-1:0] CART_OFFSET = 12'h400
) (
  input  logic                 clk,
  input  logic                 reset,
  studio2_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_DMA, OWN_CPU} own_t;

  state_t        r_state, w_state_nxt;
  own_t          r_own, w_own;
  logic [AW-1:0] r_addr, w_addr;
  logic          r_we, w_we;
  logic [7:0]    r_wdata, w_wdata;
  logic          r_oor, w_oor;
  logic [7:0]    r_cpu_rdata, r_dma_rdata;
  logic          r_cpu_ack, r_dma_ack;
  logic          r_pend_vld;
  logic [AW-1:0] r_pend_addr;
  logic [7:0]    r_pend_data;
  logic          r_ld_overrun;

  // Loader target; anything past the top of memory is discarded before arbitration.
  logic [25:0]   w_ld_sum;
  logic          w_ld_pulse;
  assign w_ld_sum   = {1'b0, bus.ld_addr} +
                      ((bus.ld_index != 8'd0) ? 26'(CART_OFFSET) : 26'd0);
  assign w_ld_pulse = bus.ld_active && bus.ld_wr && ((w_ld_sum >> AW) == 26'd0);

  // CPU decode: C00-DFF mirrors 800-9FF; only 800-9FF (and its mirror) is writable.
  logic [11:0]   w_cpu_a;
  logic          w_cpu_oor, w_cpu_wr_ok;
  always_comb begin
    w_cpu_a = bus.cpu_addr[11:0];
    if (w_cpu_a[11:10] == 2'b11 && !w_cpu_a[9]) w_cpu_a[10] = 1'b0;
  end
  assign w_cpu_oor   = |bus.cpu_addr[15:12];
  assign w_cpu_wr_ok = bus.cpu_wr && !w_cpu_oor && w_cpu_a[11] && !w_cpu_a[9];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Acks are registered, so an owner whose ack is high is still holding its req this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_own       = OWN_NONE;
    w_addr      = r_addr;
    w_we        = 1'b0;
    w_wdata     = r_wdata;
    w_oor       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_vld) begin
          w_own   = OWN_LD;
          w_addr  = r_pend_addr;
          w_we    = 1'b1;
          w_wdata = r_pend_data;
        end else if (w_ld_pulse) begin
          w_own   = OWN_LD;
          w_addr  = w_ld_sum[AW-1:0];
          w_we    = 1'b1;
          w_wdata = bus.ld_data;
        end else if (!bus.ld_active && bus.dma_req && !r_dma_ack) begin
          w_own   = OWN_DMA;
          w_addr  = VRAM_BASE + AW'(bus.dma_offs);
        end else if (!bus.ld_active && bus.cpu_req && !r_cpu_ack) begin
          w_own   = OWN_CPU;
          w_addr  = AW'(w_cpu_a);
          w_we    = w_cpu_wr_ok;
          w_wdata = bus.cpu_wdata;
          w_oor   = w_cpu_oor;
        end
        if (w_own != OWN_NONE) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: w_state_nxt = S_CAPTURE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_own       <= OWN_NONE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= 8'h00;
      r_oor       <= 1'b0;
      r_cpu_rdata <= 8'hFF;
      r_dma_rdata <= 8'hFF;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      if (w_own != OWN_NONE) begin
        r_own   <= w_own;
        r_addr  <= w_addr;
        r_we    <= w_we;
        r_wdata <= w_wdata;
        r_oor   <= w_oor;
      end
      if (r_state == S_CAPTURE) begin
        case (r_own)
          OWN_CPU: begin
            r_cpu_rdata <= r_oor ? 8'hFF : bus.mem_rdata;
            r_cpu_ack   <= 1'b1;
          end
          OWN_DMA: begin
            r_dma_rdata <= bus.mem_rdata;
            r_dma_ack   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // One-deep loader buffer; a pulse in IDLE behind a pending entry simply takes its slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_vld   <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= 8'h00;
      r_ld_overrun <= 1'b0;
    end else if (w_ld_pulse && (r_state != S_IDLE || r_pend_vld)) begin
      r_pend_vld  <= 1'b1;
      r_pend_addr <= w_ld_sum[AW-1:0];
      r_pend_data <= bus.ld_data;
      if (r_state != S_IDLE && r_pend_vld) r_ld_overrun <= 1'b1;
    end else if (r_state == S_IDLE && r_pend_vld) begin
      r_pend_vld <= 1'b0;
    end
  end

`ifdef STUDIO2_VRAM_SNOOP_EN
  logic w_cpu_vram;
  logic r_snoop;
  assign w_cpu_vram = w_cpu_wr_ok && (w_cpu_a[11:8] == 4'h9);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_snoop <= 1'b0;
    else       r_snoop <= (w_own == OWN_CPU) && w_cpu_vram;
  end
  assign bus.vram_wr_stb  = r_snoop;
  assign bus.vram_wr_data = r_wdata;
`endif

  assign bus.mem_addr   = r_addr;
  assign bus.mem_we     = r_we;
  assign bus.mem_wdata  = r_wdata;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.dma_rdata  = r_dma_rdata;
  assign bus.dma_ack    = r_dma_ack;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.ld_overrun = r_ld_overrun;
endmodule

// File: doc/studio2_mem_arbiter.md
Name: studio2_mem_arbiter

Overview:
- Sequences the single shared 4 KB system memory between three requesters: the ioctl cartridge/ROM loader, the pixie video DMA fetch, and the CDP1802 CPU bus.
- Decodes the Studio II memory map: ROM 000-3FF, cart 400-7FF, program RAM 800-8FF, VRAM 900-9FF, multicart A00-BFF, mirror C00-DFF onto 800-9FF, multicart E00-FFF.
- Enforces CPU write protection and delivers read data with a fixed-latency ack handshake.
- Sits between cdp1802/pixie_dp/ioctl and the dpram port A.

Parameters:
AW, 12, memory address width (4 KB).
VRAM_BASE, 12'h900, base address of the DMA fetch window.
CART_OFFSET, 12'h400, loader offset applied when ld_index != 0.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_wr  in  1  1 = write, 0 = read; qualified by cpu_req
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data; valid when cpu_ack
cpu_ack  out  1  one-cycle completion pulse
dma_req  in  1  video DMA fetch request (DMAO); held until dma_ack
dma_offs  in  8  byte offset within VRAM window
dma_rdata  out  8  fetched byte; valid when dma_ack
dma_ack  out  1  one-cycle completion pulse
ld_active  in  1  loader download in progress
ld_wr  in  1  loader write strobe, one cycle
ld_index  in  8  download index; 0 = system ROM image
ld_addr  in  25  loader byte address
ld_data  in  8  loader write data
mem_addr  out  AW  memory address
mem_we  out  1  memory write enable
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, one-cycle synchronous latency
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state): state IDLE; cpu_ack=0, dma_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=8'hFF, dma_rdata=8'hFF, busy=0.
- FSM: IDLE -> ISSUE -> CAPTURE -> IDLE. No new grant is made while not IDLE.
- IDLE: pick a winner, fixed priority loader > DMA > CPU. Register mem_addr, mem_we and mem_wdata, latch the grant owner, go to ISSUE.
  - The loader wins only when ld_active && ld_wr.
  - A loader pulse that arrives while the FSM is not IDLE is captured in a one-deep pending register and served at the next IDLE.
  - A second pulse while the pending register is full overwrites it and sets sticky ld_overrun (internal, cleared by reset).
- ISSUE: memory samples its inputs; mem_we returns to 0 at the next edge; go to CAPTURE.
- CAPTURE: mem_rdata is valid. Route it to the owner's rdata register, pulse the owner's ack for one cycle, go to IDLE.
  - CPU/DMA latency: ack three cycles after the request is sampled in IDLE. Loader has no ack.
- CPU decode:
  - cpu_addr[15:12] != 0: no memory cycle (mem_we=0). Read returns 8'hFF; ack keeps the same 3-cycle latency.
  - 0xC00-0xDFF is remapped to 0x800-0x9FF.
  - Writes to 000-7FF, A00-BFF or E00-FFF are dropped (mem_we forced 0) but still acked.
- DMA address: VRAM_BASE + dma_offs; read-only.
- Loader address: ld_addr when ld_index == 0, else ld_addr + CART_OFFSET.
  - If the sum is >= 4096 the write is dropped and no memory cycle is issued.
  - Loader writes ignore protection.
- When a request is dropped, the requester must wait until its ack before re-issuing; the arbiter samples req only in IDLE.
- If ld_active is asserted while a CPU/DMA cycle is in flight, that cycle completes normally.
- While ld_active is high, CPU and DMA requests are not granted; their acks stay 0 until ld_active falls.

Optional Feature:
STUDIO2_VRAM_SNOOP_EN:
- Defined: adds outputs vram_wr_stb (1) and vram_wr_data (8). These pulse in the ISSUE cycle of any CPU write that lands in 900-9FF, including via the C00 mirror.
- Undefined: the ports are absent and there is no snoop logic.

Test Plan:
- Reset mid-transaction: CPU read issued, reset asserted in ISSUE -> mem_we=0, acks 0, rdata=FF immediately, FSM IDLE.
- Mirror read: mem[0x905]=0x5A; CPU reads 0x0D05 -> mem_addr=0x905; cpu_ack 3 cycles after request, cpu_rdata=0x5A.
- Write protection: CPU writes 0x33 to 0x0123 -> ack at 3 cycles, mem_we never 1, mem[0x123] unchanged; write to 0x0810 -> mem_we=1, data 0x33.
- Simultaneous requests: dma_req (offs 0x10) and cpu_req in the same IDLE cycle -> DMA granted, mem_addr 0x910; CPU acked 3 cycles after the DMA ack, no overlap.
- Loader: ld_index=1, ld_addr=0x010, data 0xA7 -> mem[0x410]=0xA7; ld_addr=0xC00 with index 1 -> dropped; back-to-back ld_wr during busy -> both written in order.
- Out of range: CPU reads 0x1234 -> cpu_rdata=0xFF, mem_we=0, ack at 3 cycles.
